// File: rtl/block_mem_ctrl.sv
// Backing-memory controller below the data cache: serialises block refills and
// victim write-backs into word beats against a word-wide array, with a one-block write-back buffer.
module block_mem_ctrl #(
  parameter int BLOCK_BITS  = 256,
  parameter int WORD_BITS   = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [31:0]           rd_addr,
  output logic                  rd_resp_valid,
  output logic [BLOCK_BITS-1:0] rd_rdata,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_addr,
  input  logic [BLOCK_BITS-1:0] wr_data,
  output logic                  busy
);

  localparam int NWORDS = BLOCK_BITS / WORD_BITS;
  localparam int BW     = $clog2(NWORDS);
  localparam int AW     = $clog2(MEM_WORDS);
  localparam int LW     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST  = LW'(MEM_LATENCY - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RD_BEAT, WB_BEAT, RD_RESP} state_t;

  // Storage index is {block address, beat} truncated to the array depth, so high blocks alias.
  function automatic logic [AW-1:0] mem_index(input logic [26:0] blk, input logic [BW-1:0] beat);
    logic [26+BW:0] full;
    full = {blk, beat};
    return full[AW-1:0];
  endfunction

  function automatic logic [WORD_BITS-1:0] block_word(input logic [BLOCK_BITS-1:0] blk,
                                                      input logic [BW-1:0] beat);
    return blk[BLOCK_BITS-1-WORD_BITS*int'(beat) -: WORD_BITS];
  endfunction

  logic [WORD_BITS-1:0]  mem [MEM_WORDS];

  state_t                state, state_nx;
  logic                  rdy_en;
  logic                  rd_busy, rd_pend, wb_valid, resp_q;
  logic [26:0]           rd_blk, wb_blk;
  logic [BLOCK_BITS-1:0] wb_data, asm_buf, rdata_q;
  logic [BW-1:0]         rd_beat, wb_beat;
  logic [LW-1:0]         lat;

  logic                  rd_fire, wr_fire, hit_buf, hit_wr, fwd;
  logic [BLOCK_BITS-1:0] fwd_data;
  logic                  beat_done, rd_xfer, wb_xfer, rd_last, wb_last, rd_enter;
  logic [WORD_BITS-1:0]  rd_word, wb_word;
  logic [AW-1:0]         rd_idx, wb_idx;
  logic                  unused_addr_bits;

  assign rd_ready      = rdy_en & ~rd_busy;
  assign wr_ready      = rdy_en & ~wb_valid;
  assign busy          = rd_busy | wb_valid;
  assign rd_resp_valid = resp_q;
  assign rd_rdata      = rdata_q;

  assign rd_fire  = rd_valid & rd_ready;
  assign wr_fire  = wr_valid & wr_ready;
  // A read of a block still sitting in (or entering) the buffer must see the buffered data.
  assign hit_buf  = wb_valid && (wb_blk == rd_addr[31:5]);
  assign hit_wr   = wr_fire && (wr_addr[31:5] == rd_addr[31:5]);
  assign fwd      = rd_fire && (hit_buf || hit_wr);
  assign fwd_data = hit_wr ? wr_data : wb_data;

  assign beat_done = (lat == LAT_LAST);
  assign rd_xfer   = (state == RD_BEAT) && beat_done;
  assign wb_xfer   = (state == WB_BEAT) && beat_done;
  assign rd_last   = rd_xfer && (rd_beat == BEAT_LAST);
  assign wb_last   = wb_xfer && (wb_beat == BEAT_LAST);
  assign rd_enter  = (state != RD_BEAT) && (state_nx == RD_BEAT);

  assign rd_idx  = mem_index(rd_blk, rd_beat);
  assign wb_idx  = mem_index(wb_blk, wb_beat);
  assign rd_word = mem[rd_idx];
  assign wb_word = block_word(wb_data, wb_beat);

  assign unused_addr_bits = ^{rd_addr[4:0], wr_addr[4:0]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (rd_pend)       state_nx = RD_BEAT;
        else if (wb_valid) state_nx = WB_BEAT;
      end
      RD_BEAT: if (rd_last) state_nx = RD_RESP;
      WB_BEAT: begin
        // A waiting read pre-empts the drain only at a beat boundary.
        if (wb_last)                    state_nx = IDLE;
        else if (beat_done && rd_pend) state_nx = RD_BEAT;
      end
      RD_RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_en   <= 1'b0;
      rd_busy  <= 1'b0;
      rd_pend  <= 1'b0;
      wb_valid <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      rd_beat  <= '0;
      wb_beat  <= '0;
      lat      <= '0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
      resp_q <= 1'b0;

      if (state != state_nx)                           lat <= '0;
      else if ((state == RD_BEAT) || (state == WB_BEAT)) lat <= beat_done ? '0 : lat + LW'(1);

      if (rd_xfer) rd_beat <= rd_beat + BW'(1);
      if (rd_enter) begin
        rd_beat <= '0;
        rd_pend <= 1'b0;
      end
      // Beat 7 is the least significant word, so the last storage word completes the block here.
      if (rd_last) begin
        rdata_q <= {asm_buf[BLOCK_BITS-1:WORD_BITS], rd_word};
        resp_q  <= 1'b1;
        rd_busy <= 1'b0;
      end

      if (wb_xfer) wb_beat  <= wb_beat + BW'(1);
      if (wb_last) wb_valid <= 1'b0;
      if (wr_fire) begin
        wb_valid <= 1'b1;
        wb_beat  <= '0;
      end

      if (rd_fire) begin
        if (fwd) begin
          rdata_q <= fwd_data;
          resp_q  <= 1'b1;
        end else begin
          rd_pend <= 1'b1;
          rd_busy <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire) rd_blk <= rd_addr[31:5];
    if (wr_fire) begin
      wb_blk  <= wr_addr[31:5];
      wb_data <= wr_data;
    end
    if (rd_xfer) asm_buf[BLOCK_BITS-1-WORD_BITS*int'(rd_beat) -: WORD_BITS] <= rd_word;
  end

  // Storage is never reset; a reset edge must not complete an in-flight beat.
  always_ff @(posedge clk) begin
    if (rst_n && wb_xfer) mem[wb_idx] <= wb_word;
  end

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Directed bench for block_mem_ctrl: a transaction table plus hand-written
// sequences for reset, forwarding, drain pre-emption and reset mid-drain.
module tb_block_mem_ctrl;

  localparam int BB     = 256;
  localparam int LAT    = 4;
  localparam int RD_LAT = 8*LAT + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [31:0]   rd_addr = '0;
  logic          rd_resp_valid;
  logic [BB-1:0] rd_rdata;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [31:0]   wr_addr = '0;
  logic [BB-1:0] wr_data = '0;
  logic          busy;

  int tests = 0;
  int fails = 0;

  block_mem_ctrl #(.BLOCK_BITS(BB), .WORD_BITS(32), .MEM_WORDS(1024), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_rdata(rd_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [BB-1:0] data;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BB-1:0] make_blk(input logic [31:0] seed);
    logic [BB-1:0] b;
    for (int i = 0; i < 8; i++) b[BB-1-32*i -: 32] = seed + 32'(i) * 32'h0101_0101;
    return b;
  endfunction

  task automatic wait_wr_ready(output int n);
    n = 0;
    while (!wr_ready && n < 200) begin
      tick();
      n++;
    end
    if (!wr_ready) check("wr_ready_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [BB-1:0] d);
    int n;
    wait_wr_ready(n);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [BB-1:0] d, output int lat);
    int n;
    n = 0;
    while (!rd_ready && n < 200) begin
      tick();
      n++;
    end
    rd_valid = 1'b1;
    rd_addr  = a;
    tick();
    rd_valid = 1'b0;
    lat = 0;
    while (!rd_resp_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!rd_resp_valid) check("rd_resp_timeout", 0, 1);
    d = rd_rdata;
    tick();
    check("resp_pulse_width", rd_resp_valid, 0);
  endtask

  logic [BB-1:0] d1, blk_a, blk_b, got;
  int            n, lat;

  initial begin
    d1    = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
             32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
    blk_a = make_blk(32'hA000_0000);
    blk_b = make_blk(32'hB000_0000);

    vecs[0] = '{1'b0, 32'h0000_0095, d1,                     RD_LAT, "rd_0x95"};
    vecs[1] = '{1'b1, 32'h0000_0000, make_blk(32'h2000_0000), 0,      "wr_0x0"};
    vecs[2] = '{1'b0, 32'h8000_0000, make_blk(32'h2000_0000), RD_LAT, "rd_alias_0x80000000"};
    vecs[3] = '{1'b0, 32'h0000_101F, make_blk(32'h2000_0000), RD_LAT, "rd_alias_0x101f"};
    vecs[4] = '{1'b1, 32'h0000_0FE0, make_blk(32'h3000_00F0), 0,      "wr_top"};
    vecs[5] = '{1'b0, 32'h0000_0FFF, make_blk(32'h3000_00F0), RD_LAT, "rd_top"};
    vecs[6] = '{1'b0, 32'h0000_00A0, '0,                     RD_LAT, "rd_neighbour_zero"};
    vecs[7] = '{1'b1, 32'h0000_0020, make_blk(32'h4000_0000), 0,      "wr_0x20"};
    vecs[8] = '{1'b0, 32'h0000_0020, make_blk(32'h4000_0000), RD_LAT, "rd_0x20"};

    // Reset values.
    repeat (3) tick();
    check("rst_rd_ready", rd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", rd_resp_valid, 0);
    check("rst_rdata", rd_rdata, '0);
    rst_n = 1'b1;
    tick();
    check("rel_rd_ready", rd_ready, 1);
    check("rel_wr_ready", wr_ready, 1);

    // Read of untouched storage: rd_ready low for 8*LAT+1 cycles, one pulse, zero data.
    rd_valid = 1'b1;
    rd_addr  = 32'h0000_0040;
    tick();
    rd_valid = 1'b0;
    check("rd_busy_after_accept", busy, 1);
    n = 0;
    while (!rd_ready && n < 200) begin
      tick();
      n++;
    end
    check("rd_ready_low_cycles", n, RD_LAT);
    check("rd_zero_resp_valid", rd_resp_valid, 1);
    check("rd_zero_data", rd_rdata, '0);
    tick();
    check("rd_zero_pulse_end", rd_resp_valid, 0);

    // Write-back timing: buffer full next cycle, drained 8*LAT+1 cycles after accept.
    do_write(32'h0000_0080, d1);
    check("wr_ready_low", wr_ready, 0);
    check("wr_busy", busy, 1);
    wait_wr_ready(n);
    check("wr_drain_cycles", n, 8*LAT + 1);
    check("wr_idle_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data);
        wait_wr_ready(n);
      end else begin
        do_read(vecs[i].addr, got, lat);
        check({vecs[i].name, "_data"}, got, vecs[i].data);
        check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      end
    end

    // Simultaneous write and read of the same block: forwarded next cycle.
    wr_valid = 1'b1;
    wr_addr  = 32'h0000_0100;
    wr_data  = make_blk(32'h5000_0000);
    rd_valid = 1'b1;
    rd_addr  = 32'h0000_0110;
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    check("simul_resp_valid", rd_resp_valid, 1);
    check("simul_data", rd_rdata, make_blk(32'h5000_0000));
    check("simul_rd_ready", rd_ready, 1);
    tick();
    check("simul_pulse_end", rd_resp_valid, 0);
    wait_wr_ready(n);
    do_read(32'h0000_0100, got, lat);
    check("simul_stored", got, make_blk(32'h5000_0000));

    // Read of a block held in the buffer is forwarded with no storage beats.
    do_write(32'h0000_0500, make_blk(32'h6000_0000));
    do_read(32'h0000_0500, got, lat);
    check("buf_fwd_data", got, make_blk(32'h6000_0000));
    check("buf_fwd_lat", lat, 0);
    wait_wr_ready(n);

    // Read arriving during a drain: write accepted at edge 0, read at edge 6.
    // Beat 1 completes at edge 9, read finishes at edge 41, drain resumes at beat 2 and ends at edge 67.
    do_write(32'h0000_0300, make_blk(32'h7000_0000));
    wait_wr_ready(n);
    do_write(32'h0000_0200, make_blk(32'h8000_0000));
    repeat (5) tick();
    check("pause_rd_ready", rd_ready, 1);
    do_read(32'h0000_0300, got, lat);
    check("pause_rd_data", got, make_blk(32'h7000_0000));
    check("pause_rd_lat", lat, 35);
    check("pause_still_busy", busy, 1);
    wait_wr_ready(n);
    check("pause_resume_cycles", n, 25);
    do_read(32'h0000_0200, got, lat);
    check("pause_wb_stored", got, make_blk(32'h8000_0000));

    // Reset during drain beat 3: words 0-2 new, 3-7 old.
    do_write(32'h0000_0400, blk_a);
    wait_wr_ready(n);
    do_write(32'h0000_0400, blk_b);
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_rd_ready", rd_ready, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_resp_valid", rd_resp_valid, 0);
    check("mid_rst_rdata", rd_rdata, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_wr_ready", wr_ready, 1);
    check("mid_rel_rd_ready", rd_ready, 1);
    do_read(32'h0000_0400, got, lat);
    check("mid_rst_partial", got, {blk_b[255:160], blk_a[159:0]});
    check("mid_rst_lat", lat, RD_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
